ex_fu_sequencer: RTL and testbench

- EX-stage functional-unit sequencer.
- Takes the decoded op class of the instruction currently in EX.
  - Single-cycle classes (add, logic) complete in the issue cycle.
  - Multi-cycle classes: the fixed-latency multiplier is timed by an internal counter; the divider runs on a start/done handshake.
- Stalls the front end while a multi-cycle op is in flight.
- Drives the 4-bit one-hot result-select of the EX result mux and the EX result-valid.

---
 rtl/ex_fu_sequencer_pkg.sv | 21 ++
 rtl/ex_mul_timer.sv | 24 ++
 rtl/ex_fu_sequencer.sv | 125 ++++++++++++
 tb/tb_ex_fu_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ex_fu_sequencer_pkg.sv
// Shared definitions for the EX functional-unit sequencer: op-class codes and FSM states.
package ex_fu_sequencer_pkg;

  localparam logic [3:0] CLASS_ADD   = 4'b0001;
  localparam logic [3:0] CLASS_MUL   = 4'b0010;
  localparam logic [3:0] CLASS_DIV   = 4'b0100;
  localparam logic [3:0] CLASS_LOGIC = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } fu_state_e;

  // True when exactly one bit of the class vector is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/ex_mul_timer.sv
// Loadable down-counter that times the fixed-latency multiplier.
module ex_mul_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ex_fu_sequencer.sv
// EX-stage FU sequencer: issues single-cycle ops directly, sequences mul/div and stalls the front end.
module ex_fu_sequencer
  import ex_fu_sequencer_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [3:0] issue_class,
  input  logic       flush,
  input  logic       div_done,
  output logic       mul_start,
  output logic       div_start,
  output logic       div_cancel,
  output logic       stall_req,
  output logic [3:0] result_sel,
  output logic       result_valid,
  output logic       illegal_class
);

  // The issue cycle and the DONE cycle account for two of the latency cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2) : '0;

  fu_state_e  state, state_d;
  logic [3:0] class_q, class_d;
  logic       cnt_load, cnt_dec, cnt_zero;

  ex_mul_timer #(.CNT_W(CNT_W)) u_mul_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (MUL_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State and latched op class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      class_q <= 4'd0;
    end else begin
      state   <= state_d;
      class_q <= class_d;
    end
  end

  // Next-state and outputs; everything is held at zero while reset is asserted.
  always_comb begin
    state_d       = state;
    class_d       = class_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    mul_start     = 1'b0;
    div_start     = 1'b0;
    div_cancel    = 1'b0;
    stall_req     = 1'b0;
    result_sel    = 4'd0;
    result_valid  = 1'b0;
    illegal_class = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (issue_valid && !flush) begin
            if (!is_onehot4(issue_class)) begin
              illegal_class = 1'b1;
              result_valid  = 1'b1;
            end else if (issue_class == CLASS_MUL) begin
              mul_start = 1'b1;
              stall_req = 1'b1;
              class_d   = CLASS_MUL;
              if (MUL_LATENCY == 1) begin
                state_d = ST_DONE;
              end else begin
                cnt_load = 1'b1;
                state_d  = ST_MUL_WAIT;
              end
            end else if (issue_class == CLASS_DIV) begin
              div_start = 1'b1;
              stall_req = 1'b1;
              class_d   = CLASS_DIV;
              state_d   = ST_DIV_WAIT;
            end else begin
              result_sel   = issue_class;
              result_valid = 1'b1;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (flush) begin
            state_d = ST_IDLE;
            class_d = 4'd0;
          end else begin
            stall_req = 1'b1;
            if (cnt_zero) state_d = ST_DONE;
            else          cnt_dec = 1'b1;
          end
        end
        ST_DIV_WAIT: begin
          if (flush) begin
            div_cancel = 1'b1;
            state_d    = ST_IDLE;
            class_d    = 4'd0;
          end else begin
            stall_req = 1'b1;
            if (div_done) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          if (flush) begin
            class_d = 4'd0;
          end else begin
            result_sel   = class_q;
            result_valid = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_fu_sequencer.sv
// Directed bench for ex_fu_sequencer (MUL_LATENCY=3 main instance, MUL_LATENCY=1 secondary).
module tb_ex_fu_sequencer;
  import ex_fu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic [3:0] issue_class = 4'd0;
  logic       flush = 1'b0;
  logic       div_done = 1'b0;

  logic       mul_start, div_start, div_cancel, stall_req, result_valid, illegal_class;
  logic [3:0] result_sel;
  logic       mul_start1, div_start1, div_cancel1, stall_req1, result_valid1, illegal_class1;
  logic [3:0] result_sel1;

  int checks = 0;
  int failures = 0;

  // {mul_start, div_start, div_cancel, stall_req, result_sel, result_valid, illegal_class}
  logic [9:0] obs, obs1;
  assign obs  = {mul_start, div_start, div_cancel, stall_req, result_sel, result_valid, illegal_class};
  assign obs1 = {mul_start1, div_start1, div_cancel1, stall_req1, result_sel1, result_valid1, illegal_class1};

  localparam logic [9:0] E_IDLE  = 10'b0000_0000_00;
  localparam logic [9:0] E_ADD   = 10'b0000_0001_10;
  localparam logic [9:0] E_LOGIC = 10'b0000_1000_10;
  localparam logic [9:0] E_MULS  = 10'b1001_0000_00;
  localparam logic [9:0] E_STALL = 10'b0001_0000_00;
  localparam logic [9:0] E_MULD  = 10'b0000_0010_10;
  localparam logic [9:0] E_DIVS  = 10'b0101_0000_00;
  localparam logic [9:0] E_DIVD  = 10'b0000_0100_10;
  localparam logic [9:0] E_CANC  = 10'b0010_0000_00;
  localparam logic [9:0] E_ILL   = 10'b0000_0000_11;

  always #5 clk = ~clk;

  ex_fu_sequencer #(.MUL_LATENCY(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_class(issue_class),
    .flush(flush), .div_done(div_done), .mul_start(mul_start), .div_start(div_start),
    .div_cancel(div_cancel), .stall_req(stall_req), .result_sel(result_sel),
    .result_valid(result_valid), .illegal_class(illegal_class)
  );

  ex_fu_sequencer #(.MUL_LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_class(issue_class),
    .flush(flush), .div_done(div_done), .mul_start(mul_start1), .div_start(div_start1),
    .div_cancel(div_cancel1), .stall_req(stall_req1), .result_sel(result_sel1),
    .result_valid(result_valid1), .illegal_class(illegal_class1)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    issue_valid = 1'b0; flush = 1'b0; div_done = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 1'b1; issue_class = CLASS_MUL;
    cyc(); cyc();
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL reset_hold got=%b exp=%b", obs, E_IDLE); end
    rst_n = 1'b1; #1;
    checks++; if (obs !== E_MULS) begin failures++; $display("FAIL reset_mul_issue got=%b exp=%b", obs, E_MULS); end
    cyc();
    checks++; if (obs !== E_STALL) begin failures++; $display("FAIL reset_mul_wait got=%b exp=%b", obs, E_STALL); end
    #2 rst_n = 1'b0; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL reset_async got=%b exp=%b", obs, E_IDLE); end
    cyc();
    rst_n = 1'b1; issue_valid = 1'b0; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, E_IDLE); end
    issue_class = CLASS_ADD; issue_valid = 1'b1; #1;
    checks++; if (obs !== E_ADD) begin failures++; $display("FAIL reset_idle_add got=%b exp=%b", obs, E_ADD); end
    cyc();
    issue_valid = 1'b0;
  endtask

  task automatic test_add_logic();
    issue_valid = 1'b1; issue_class = CLASS_ADD; #1;
    checks++; if (obs !== E_ADD) begin failures++; $display("FAIL add got=%b exp=%b", obs, E_ADD); end
    cyc();
    issue_class = CLASS_LOGIC; #1;
    checks++; if (obs !== E_LOGIC) begin failures++; $display("FAIL logic got=%b exp=%b", obs, E_LOGIC); end
    cyc();
    issue_valid = 1'b0; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL add_logic_idle got=%b exp=%b", obs, E_IDLE); end
  endtask

  task automatic test_mul();
    idle_cycles(2);
    issue_valid = 1'b1; issue_class = CLASS_MUL; #1;
    checks++; if (obs !== E_MULS) begin failures++; $display("FAIL mul_T got=%b exp=%b", obs, E_MULS); end
    cyc();
    checks++; if (obs !== E_STALL) begin failures++; $display("FAIL mul_T1 got=%b exp=%b", obs, E_STALL); end
    cyc();
    checks++; if (obs !== E_STALL) begin failures++; $display("FAIL mul_T2 got=%b exp=%b", obs, E_STALL); end
    cyc();
    checks++; if (obs !== E_MULD) begin failures++; $display("FAIL mul_T3 got=%b exp=%b", obs, E_MULD); end
    cyc();
    issue_valid = 1'b0; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL mul_T4 got=%b exp=%b", obs, E_IDLE); end
  endtask

  task automatic test_mul_lat1();
    idle_cycles(5);
    issue_valid = 1'b1; issue_class = CLASS_MUL; #1;
    checks++; if (obs1 !== E_MULS) begin failures++; $display("FAIL mul1_T got=%b exp=%b", obs1, E_MULS); end
    cyc();
    issue_valid = 1'b0; #1;
    checks++; if (obs1 !== E_MULD) begin failures++; $display("FAIL mul1_T1 got=%b exp=%b", obs1, E_MULD); end
    cyc();
    checks++; if (obs1 !== E_IDLE) begin failures++; $display("FAIL mul1_T2 got=%b exp=%b", obs1, E_IDLE); end
    idle_cycles(5);
  endtask

  task automatic test_div();
    issue_valid = 1'b0; div_done = 1'b1; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL div_stray got=%b exp=%b", obs, E_IDLE); end
    cyc();
    div_done = 1'b0; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL div_stray_after got=%b exp=%b", obs, E_IDLE); end
    issue_valid = 1'b1; issue_class = CLASS_DIV; #1;
    checks++; if (obs !== E_DIVS) begin failures++; $display("FAIL div_T got=%b exp=%b", obs, E_DIVS); end
    for (int k = 1; k <= 17; k++) begin
      cyc();
      div_done = (k == 17); #1;
      checks++; if (obs !== E_STALL) begin failures++; $display("FAIL div_wait k=%0d got=%b exp=%b", k, obs, E_STALL); end
    end
    cyc();
    div_done = 1'b0; #1;
    checks++; if (obs !== E_DIVD) begin failures++; $display("FAIL div_T18 got=%b exp=%b", obs, E_DIVD); end
    cyc();
    issue_valid = 1'b0; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL div_T19 got=%b exp=%b", obs, E_IDLE); end
  endtask

  task automatic test_flush_div(input logic with_done);
    idle_cycles(3);
    issue_valid = 1'b1; issue_class = CLASS_DIV; #1;
    checks++; if (obs !== E_DIVS) begin failures++; $display("FAIL flush_div_T got=%b exp=%b", obs, E_DIVS); end
    repeat (4) cyc();
    checks++; if (obs !== E_STALL) begin failures++; $display("FAIL flush_div_T4 got=%b exp=%b", obs, E_STALL); end
    cyc();
    flush = 1'b1; div_done = with_done; #1;
    checks++; if (obs !== E_CANC) begin failures++; $display("FAIL flush_div_T5 done=%0b got=%b exp=%b", with_done, obs, E_CANC); end
    cyc();
    flush = 1'b0; div_done = 1'b0; issue_valid = 1'b0; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL flush_div_T6 done=%0b got=%b exp=%b", with_done, obs, E_IDLE); end
    cyc();
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL flush_div_T7 done=%0b got=%b exp=%b", with_done, obs, E_IDLE); end
  endtask

  task automatic test_flush_mul();
    idle_cycles(3);
    issue_valid = 1'b1; issue_class = CLASS_MUL; #1;
    cyc();
    flush = 1'b1; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL flush_mul got=%b exp=%b", obs, E_IDLE); end
    cyc();
    flush = 1'b0; issue_valid = 1'b0; #1;
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL flush_mul_after got=%b exp=%b", obs, E_IDLE); end
    cyc();
    checks++; if (obs !== E_IDLE) begin failures++; $display("FAIL flush_mul_no_result got=%b exp=%b", obs, E_IDLE); end
  endtask

  task automatic test_illegal();
    idle_cycles(3);
    issue_valid = 1'b1; issue_class = 4'b0110; #1;
    checks++; if (obs !== E_ILL) begin failures++; $display("FAIL illegal_0110 got=%b exp=%b", obs, E_ILL); end
    cyc();
    issue_class = 4'b0000; #1;
    checks++; if (obs !== E_ILL) begin failures++; $display("FAIL illegal_0000 got=%b exp=%b", obs, E_ILL); end
    cyc();
    issue_class = CLASS_ADD; #1;
    checks++; if (obs !== E_ADD) begin failures++; $display("FAIL illegal_then_add got=%b exp=%b", obs, E_ADD); end
    cyc();
    issue_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_logic();
    test_mul();
    test_mul_lat1();
    test_div();
    test_flush_div(1'b0);
    test_flush_div(1'b1);
    test_flush_mul();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
